// File: rtl/abacus_pkg.sv
// Shared types and helpers for the ABACUS cache profiler.
// It holds the tracker state encoding, the enable-register bit positions and a saturating add.
package abacus_pkg;

    typedef enum logic [1:0] {IDLE, HIT_HOLD, MISS_WAIT, SKIP} cache_prof_state_t;

    localparam int PROF_EN_BIT  = 0;
    localparam int PROF_CLR_BIT = 1;

    // Adds two values and clamps the result at max_val. A 65-bit sum keeps the carry out.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input logic [63:0] max_val);
        logic [64:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_val}) ? max_val : sum[63:0];
    endfunction

endpackage

// File: rtl/cache_event_tracker.sv
// One cache channel: a request FSM plus saturating hit, miss, request and latency counters.
// Clear zeroes the counters only; the FSM state and the in-flight latency carry on.
module cache_event_tracker
    import abacus_pkg::*;
#(
    parameter int COUNTER_WIDTH = 32,
    parameter int LATENCY_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     clr,
    input  logic                     req,
    input  logic                     hit,
    output logic [COUNTER_WIDTH-1:0] hit_counter,
    output logic [COUNTER_WIDTH-1:0] miss_counter,
    output logic [COUNTER_WIDTH-1:0] request_counter,
    output logic [COUNTER_WIDTH-1:0] miss_latency_total,
    output logic [LATENCY_WIDTH-1:0] miss_latency_max
);

    localparam logic [63:0] CNT_MAX = (64'd1 << COUNTER_WIDTH) - 64'd1;
    localparam logic [63:0] LAT_MAX = (64'd1 << LATENCY_WIDTH) - 64'd1;

    cache_prof_state_t        state, next_state;
    logic [LATENCY_WIDTH-1:0] lat;
    logic                     start, miss_done;

    function automatic logic [COUNTER_WIDTH-1:0] inc_cnt(input logic [COUNTER_WIDTH-1:0] v);
        return COUNTER_WIDTH'(sat_add(64'(v), 64'd1, CNT_MAX));
    endfunction

    // Enable is sampled only here, in the first cycle of a request.
    assign start     = (state == IDLE) && req && en;
    assign miss_done = (state == MISS_WAIT) && !req;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (req) next_state = !en ? SKIP : (hit ? HIT_HOLD : MISS_WAIT);
            HIT_HOLD:  if (!req) next_state = IDLE;
            MISS_WAIT: if (!req) next_state = IDLE;
            SKIP:      if (!req) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= IDLE;
            lat                <= '0;
            hit_counter        <= '0;
            miss_counter       <= '0;
            request_counter    <= '0;
            miss_latency_total <= '0;
            miss_latency_max   <= '0;
        end else begin
            state <= next_state;
            if (start && !hit)
                lat <= LATENCY_WIDTH'(1);
            else if (state == MISS_WAIT && req)
                lat <= LATENCY_WIDTH'(sat_add(64'(lat), 64'd1, LAT_MAX));

            if (clr) begin
                hit_counter        <= '0;
                miss_counter       <= '0;
                request_counter    <= '0;
                miss_latency_total <= '0;
                miss_latency_max   <= '0;
            end else begin
                if (start) begin
                    request_counter <= inc_cnt(request_counter);
                    if (hit) hit_counter  <= inc_cnt(hit_counter);
                    else     miss_counter <= inc_cnt(miss_counter);
                end
                if (miss_done) begin
                    miss_latency_total <= COUNTER_WIDTH'(sat_add(64'(miss_latency_total),
                                                                 64'(lat), CNT_MAX));
                    if (lat > miss_latency_max) miss_latency_max <= lat;
                end
            end
        end
    end

endmodule

// File: rtl/cache_profiler.sv
// ABACUS cache profiler top: independent I-cache and D-cache event trackers.
// The trackers share the enable/clear bits of the cache-profile enable register.
module cache_profiler
    import abacus_pkg::*;
#(
    parameter int COUNTER_WIDTH = 32,
    parameter int LATENCY_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              enable,
    input  logic                     icache_requests,
    input  logic                     icache_hits,
    input  logic                     dcache_requests,
    input  logic                     dcache_hits,
    output logic [COUNTER_WIDTH-1:0] icache_hit_counter,
    output logic [COUNTER_WIDTH-1:0] icache_miss_counter,
    output logic [COUNTER_WIDTH-1:0] icache_request_counter,
    output logic [COUNTER_WIDTH-1:0] icache_miss_latency_total,
    output logic [LATENCY_WIDTH-1:0] icache_miss_latency_max,
    output logic [COUNTER_WIDTH-1:0] dcache_hit_counter,
    output logic [COUNTER_WIDTH-1:0] dcache_miss_counter,
    output logic [COUNTER_WIDTH-1:0] dcache_request_counter,
    output logic [COUNTER_WIDTH-1:0] dcache_miss_latency_total,
    output logic [LATENCY_WIDTH-1:0] dcache_miss_latency_max
);

    // The upper enable bits are reserved and have no effect.
    logic unused_enable;
    assign unused_enable = ^enable[31:2];

    cache_event_tracker #(.COUNTER_WIDTH(COUNTER_WIDTH), .LATENCY_WIDTH(LATENCY_WIDTH)) u_icache (
        .clk                (clk),
        .rst                (rst),
        .en                 (enable[PROF_EN_BIT]),
        .clr                (enable[PROF_CLR_BIT]),
        .req                (icache_requests),
        .hit                (icache_hits),
        .hit_counter        (icache_hit_counter),
        .miss_counter       (icache_miss_counter),
        .request_counter    (icache_request_counter),
        .miss_latency_total (icache_miss_latency_total),
        .miss_latency_max   (icache_miss_latency_max)
    );

    cache_event_tracker #(.COUNTER_WIDTH(COUNTER_WIDTH), .LATENCY_WIDTH(LATENCY_WIDTH)) u_dcache (
        .clk                (clk),
        .rst                (rst),
        .en                 (enable[PROF_EN_BIT]),
        .clr                (enable[PROF_CLR_BIT]),
        .req                (dcache_requests),
        .hit                (dcache_hits),
        .hit_counter        (dcache_hit_counter),
        .miss_counter       (dcache_miss_counter),
        .request_counter    (dcache_request_counter),
        .miss_latency_total (dcache_miss_latency_total),
        .miss_latency_max   (dcache_miss_latency_max)
    );

endmodule
